// File: rtl/fpround_pipe_if.sv
// Handshake and data bundle between an upstream producer, the rounding pipe
// and its downstream consumer.
interface fpround_pipe_if #(
  parameter int NE = 5,
  parameter int NF = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    roundmode;
  logic          m_sign;
  logic [NE+1:0] m_exp;
  logic [NF-1:0] m_fract;
  logic          guard;
  logic          sticky;
  logic          out_valid;
  logic          out_ready;
  logic          r_sign;
  logic [NE-1:0] r_exp;
  logic [NF-1:0] r_fract;
  logic          flag_of;
  logic          flag_nx;

  modport master (
    output in_valid, roundmode, m_sign, m_exp, m_fract, guard, sticky, out_ready,
    input  in_ready, out_valid, r_sign, r_exp, r_fract, flag_of, flag_nx
  );

  modport slave (
    input  in_valid, roundmode, m_sign, m_exp, m_fract, guard, sticky, out_ready,
    output in_ready, out_valid, r_sign, r_exp, r_fract, flag_of, flag_nx
  );
endinterface

// File: rtl/fpround_pipe.sv
// Two-stage floating-point rounding pipeline: stage 1 captures the operand and
// decides the increment, stage 2 applies it and resolves overflow.
module fpround_pipe #(
  parameter int NE = 5,
  parameter int NF = 10
) (
  input logic          clk,
  input logic          reset,
  fpround_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_t;

  localparam logic [NE+2:0] EMAX_W = (NE+3)'((1 << NE) - 2);
  localparam logic [NE-1:0] EMAX_E = NE'((1 << NE) - 2);

  logic          s1_valid;
  logic          s1_sign;
  logic [NE+1:0] s1_exp;
  logic [NF-1:0] s1_fract;
  logic          s1_incr;
  logic          s1_nx;
  rmode_t        s1_mode;

  logic          s2_valid;
  logic          r_sign;
  logic [NE-1:0] r_exp;
  logic [NF-1:0] r_fract;
  logic          flag_of;
  logic          flag_nx;

  logic          s2_advance;
  logic          s1_advance;
  logic          accept;
  rmode_t        mode_in;
  logic          incr_in;

  logic          carry;
  logic [NF-1:0] fract_sum;
  logic [NE+2:0] exp_post;
  logic          ovf;
  logic          to_inf;
  logic [NE-1:0] r_exp_d;
  logic [NF-1:0] r_fract_d;

  assign s2_advance   = !s2_valid | bus.out_ready;
  assign s1_advance   = s1_valid & s2_advance;
  assign bus.in_ready = !reset & (!s1_valid | s1_advance);
  assign accept       = bus.in_valid & bus.in_ready;

  // Unused encodings 101..111 fall back to round-to-nearest-even.
  always_comb begin
    mode_in = RM_RNE;
    incr_in = 1'b0;
    case (bus.roundmode)
      3'b001:  mode_in = RM_RTZ;
      3'b010:  mode_in = RM_RDN;
      3'b011:  mode_in = RM_RUP;
      3'b100:  mode_in = RM_RMM;
      default: mode_in = RM_RNE;
    endcase
    case (mode_in)
      RM_RNE:  incr_in = bus.guard & (bus.m_fract[0] | bus.sticky);
      RM_RTZ:  incr_in = 1'b0;
      RM_RDN:  incr_in = bus.m_sign & (bus.guard | bus.sticky);
      RM_RUP:  incr_in = !bus.m_sign & (bus.guard | bus.sticky);
      RM_RMM:  incr_in = bus.guard;
      default: incr_in = 1'b0;
    endcase
  end

  // The hidden bit only carries out when the whole stored fraction wraps, so
  // adding to the fraction alone yields the same carry as {1,fraction}+incr.
  always_comb begin
    {carry, fract_sum} = {1'b0, s1_fract} + {{NF{1'b0}}, s1_incr};
    exp_post  = {1'b0, s1_exp} + {{(NE+2){1'b0}}, carry};
    ovf       = exp_post > EMAX_W;
    to_inf    = 1'b1;
    case (s1_mode)
      RM_RTZ:  to_inf = 1'b0;
      RM_RUP:  to_inf = !s1_sign;
      RM_RDN:  to_inf = s1_sign;
      default: to_inf = 1'b1;
    endcase
    r_exp_d   = exp_post[NE-1:0];
    r_fract_d = fract_sum;
    if (ovf) begin
      r_exp_d   = to_inf ? '1 : EMAX_E;
      r_fract_d = to_inf ? '0 : '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_fract <= '0;
      s1_incr  <= 1'b0;
      s1_nx    <= 1'b0;
      s1_mode  <= RM_RNE;
      s2_valid <= 1'b0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_fract  <= '0;
      flag_of  <= 1'b0;
      flag_nx  <= 1'b0;
    end else begin
      s1_valid <= accept | (s1_valid & !s1_advance);
      if (accept) begin
        s1_sign  <= bus.m_sign;
        s1_exp   <= bus.m_exp;
        s1_fract <= bus.m_fract;
        s1_incr  <= incr_in;
        s1_nx    <= bus.guard | bus.sticky;
        s1_mode  <= mode_in;
      end
      if (s2_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          r_sign  <= s1_sign;
          r_exp   <= r_exp_d;
          r_fract <= r_fract_d;
          flag_of <= ovf;
          flag_nx <= s1_nx | ovf;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.r_sign    = r_sign;
  assign bus.r_exp     = r_exp;
  assign bus.r_fract   = r_fract;
  assign bus.flag_of   = flag_of;
  assign bus.flag_nx   = flag_nx;

endmodule
